// File: rtl/pri_encoder_rr_if.sv
`default_nettype none
// ==========================================================================
// pri_encoder_rr_if : request/result handshake bundle for pri_encoder_rr
// Revision 1.0
// ==========================================================================
interface pri_encoder_rr_if #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
);
  logic             mode_rr;
  logic [N-1:0]     data_in;
  logic             in_valid;
  logic             in_ready;
  logic [IDX_W-1:0] y_out;
  logic [N-1:0]     onehot_out;
  logic             data_valid;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output mode_rr, data_in, in_valid, out_ready,
    input  in_ready, y_out, onehot_out, data_valid, out_valid
  );

  modport slave (
    input  mode_rr, data_in, in_valid, out_ready,
    output in_ready, y_out, onehot_out, data_valid, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/pri_encoder_rr.sv
`default_nettype none
// ==========================================================================
// pri_encoder_rr : registered fixed/round-robin priority encoder, valid/ready
// Revision 1.0
// ==========================================================================
module pri_encoder_rr #(
  parameter int N = 8
) (
  input  logic                clk,
  input  logic                reset,
  pri_encoder_rr_if.slave     bus
);
  localparam int IDX_W = $clog2(N);

  logic [IDX_W-1:0] ptr;
  logic [N-1:0]     masked;
  logic             any_req;
  logic             any_masked;
  logic [IDX_W-1:0] grant_idx;
  logic [N-1:0]     grant_oh;
  logic             accept;

  logic             out_valid_q;
  logic             data_valid_q;
  logic [IDX_W-1:0] y_q;
  logic [N-1:0]     onehot_q;

  function automatic logic [IDX_W-1:0] msb_index(input logic [N-1:0] vec);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  // Round-robin: the highest request at or below ptr wins; if none, the
  // search has wrapped, so the highest request overall wins.
  for (genvar i = 0; i < N; i++) begin : g_mask
    assign masked[i] = bus.data_in[i] & (IDX_W'(i) <= ptr);
  end

  always_comb begin
    any_req    = |bus.data_in;
    any_masked = |masked;
    grant_idx  = (bus.mode_rr && any_masked) ? msb_index(masked)
                                             : msb_index(bus.data_in);
    grant_oh   = any_req ? (N'(1) << grant_idx) : '0;
  end

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      data_valid_q <= 1'b0;
      y_q          <= '0;
      onehot_q     <= '0;
      ptr          <= IDX_W'(N - 1);
    end else if (accept) begin
      out_valid_q  <= 1'b1;
      data_valid_q <= any_req;
      y_q          <= grant_idx;
      onehot_q     <= grant_oh;
      if (bus.mode_rr && any_req) begin
        ptr <= (grant_idx == '0) ? IDX_W'(N - 1) : grant_idx - 1'b1;
      end
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.data_valid = data_valid_q;
  assign bus.y_out      = y_q;
  assign bus.onehot_out = onehot_q;
endmodule
`default_nettype wire
